regbank_arbiter: RTL
====================

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, register-bank address width.
REQ-002 Parameter: DATA_W, 32, register-bank data width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: cmd_valid[i], i=0..1  input  1 each  requester i presents a command.
REQ-006 Port: cmd_write[i]  input  1 each  1 = write, 0 = read.
REQ-007 Port: cmd_addr[i]  input  ADDR_W each  target register.
REQ-008 Port: cmd_wdata[i]  input  DATA_W each  write data.
REQ-009 Port: cmd_ready[i]  output  1 each  command accepted this cycle.
REQ-010 Port: rsp_valid[i]  output  1 each  one-cycle completion pulse.
REQ-011 Port: rsp_rdata  output  DATA_W  read data, shared, valid with rsp_valid.
REQ-012 Port: rsp_err  output  1  completion error, valid with rsp_valid.
REQ-013 Port: rb_addr, rb_wdata  output  ADDR_W, DATA_W  to register bank addr/wdata.
REQ-014 Port: rb_write_en, rb_read_en  output  1 each  to register bank write_en/read_en.
REQ-015 Port: rb_rdata  input  DATA_W  register bank rdata, valid cycle after rb_read_en.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, RESP; one command in flight at a time.
REQ-017 In IDLE, cmd_ready[i] SHALL be combinational: 1 only for the arbitration winner with cmd_valid[i]=1; accepted command latched (owner, write, addr, wdata) at that edge.
REQ-018 Arbitration SHALL be round-robin: sole valid requester wins; both valid -> requester not granted last wins; last-grant pointer updates on every accept.
REQ-019 IDLE->WRITE on accepted write; IDLE->READ on accepted read; no valid -> stay IDLE.
REQ-020 WRITE (1 cycle): rb_write_en=1, rb_addr/rb_wdata = latched values, rsp_valid[owner]=1, rsp_rdata=0; -> IDLE.
REQ-021 READ (1 cycle): rb_read_en=1, rb_addr = latched addr; -> RESP.
REQ-022 RESP (1 cycle): rsp_valid[owner]=1, rsp_rdata=rb_rdata; -> IDLE.
REQ-023 Latency: write accept-to-response 1 cycle, read 2 cycles; next accept earliest in cycle after response.
REQ-024 rb_write_en and rb_read_en SHALL never be 1 simultaneously; outside WRITE/READ both 0.
REQ-025 cmd_ready SHALL be 0 in all states but IDLE; requester holds command until cmd_ready.
REQ-026 rsp_valid SHALL never be 1 for both requesters in one cycle; rsp_err=0 except per REQ-030.
REQ-027 Addresses full range 0..2^ADDR_W-1, no wrap or truncation; rb_addr/rb_wdata hold latched values while not IDLE.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rb_write_en=0, rb_read_en=0, rb_addr=0, rb_wdata=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-029 Reset mid-command SHALL abandon it with no response; first accept allowed first cycle after rst deasserts.

Configuration
REQ-030 Macro REGBANK_ARB_RO0_EN defined: write to address 0 SHALL complete through WRITE with rb_write_en=0 and rsp_err=1 with rsp_valid; reads of address 0 unaffected.
REQ-031 Macro undefined: address 0 writable as any other; rsp_err tied 0.

Verification
REQ-032 Req0 write addr 5, data 0xDEADBEEF -> cmd_ready[0] cycle 0, rb_write_en=1 addr 5 cycle 1, rsp_valid[0] cycle 1.
REQ-033 Req1 read addr 5 after REQ-032 -> rb_read_en cycle 1, rsp_valid[1] cycle 2 with rsp_rdata=0xDEADBEEF.
REQ-034 Both valid continuously from reset, reads addr 3 and 7 -> grants 0,1,0,1, no double rsp_valid, read enables never overlap with write enables.
REQ-035 rst asserted during READ -> all outputs 0 same cycle, no rsp_valid; post-reset req1-alone command granted immediately.
REQ-036 REGBANK_ARB_RO0_EN defined, write addr 0 data 0x1 -> rb_write_en stays 0, rsp_valid=1 with rsp_err=1; subsequent read addr 0 returns prior value; macro undefined -> write lands, rsp_err=0.

Source files
------------

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register bank.
// Optional REGBANK_ARB_RO0_EN makes address 0 read-only (writes complete with rsp_err).
module regbank_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cmd_valid,
    input  logic [1:0]        cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr  [2],
    input  logic [DATA_W-1:0] cmd_wdata [2],
    output logic [1:0]        cmd_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_wdata,
    output logic              rb_write_en,
    output logic              rb_read_en,
    input  logic [DATA_W-1:0] rb_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              owner;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t state;
    state_t state_nxt;
    cmd_t   cur;
    logic   last_grant;
    logic   winner;
    logic   accept;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        if (cmd_valid == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = cmd_valid[1];
        end
    end

    // Next state and state-decoded outputs; cmd_ready is gated by rst so reset masks it at once.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        cmd_ready   = 2'b00;
        rsp_valid   = 2'b00;
        rsp_rdata   = '0;
        rsp_err     = 1'b0;
        rb_write_en = 1'b0;
        rb_read_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && cmd_valid[winner]) begin
                    accept            = 1'b1;
                    cmd_ready[winner] = 1'b1;
                    state_nxt         = cmd_write[winner] ? WRITE : READ;
                end
            end
            WRITE: begin
                rsp_valid[cur.owner] = 1'b1;
                rb_write_en          = 1'b1;
`ifdef REGBANK_ARB_RO0_EN
                if (cur.addr == '0) begin
                    rb_write_en = 1'b0;
                    rsp_err     = 1'b1;
                end
`endif
                state_nxt = IDLE;
            end
            READ: begin
                rb_read_en = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp_valid[cur.owner] = 1'b1;
                rsp_rdata            = rb_rdata;
                state_nxt            = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur.owner  <= winner;
                cur.write  <= cmd_write[winner];
                cur.addr   <= cmd_addr[winner];
                cur.wdata  <= cmd_wdata[winner];
                last_grant <= winner;
            end
        end
    end

    assign rb_addr  = cur.addr;
    assign rb_wdata = cur.wdata;

endmodule
